// File: rtl/controllore_pkg.sv
// Shared types and constants for the match control FSM and its optional timeout counter.
package controllore_pkg;

    typedef enum logic [1:0] {
        RIPOSO = 2'b00,
        SETUP  = 2'b01,
        GIOCO  = 2'b10,
        FINE   = 2'b11
    } stato_t;

    localparam logic [1:0] ESITO_NESSUNO = 2'b00;
    localparam logic [1:0] ESITO_PRIMO   = 2'b01;
    localparam logic [1:0] ESITO_SECONDO = 2'b10;
    localparam logic [1:0] ESITO_PARI    = 2'b11;

    localparam int MANCHE_BASE_DEFAULT = 4;

endpackage

// File: rtl/contatore_timeout.sv
// Idle-cycle counter with clear, count enable and a terminal-count strobe on the LIMITE-th counted cycle.
module contatore_timeout #(
    parameter int LIMITE = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic conta,
    output logic terminale
);

    localparam int W = $clog2(LIMITE + 1);
    localparam logic [W-1:0] ULTIMO = W'(LIMITE - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (conta && (cnt_q != ULTIMO)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminale = conta && !clear && (cnt_q == ULTIMO);

endmodule

// File: rtl/controllore_partita.sv
// Match control FSM: setup pulse, counting enable, result latch with valid/ack handshake.
// Optional idle timeout in GIOCO is enabled by defining CONTROLLO_TIMEOUT_EN.
module controllore_partita
    import controllore_pkg::*;
#(
    parameter int CONT_W        = 5,
    parameter int MANCHE_BASE   = MANCHE_BASE_DEFAULT,
    parameter int TIMEOUT_CICLI = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              INIZIO,
    input  logic              MOSSA_VALIDA,
    input  logic [1:0]        PRIMO,
    input  logic [1:0]        SECONDO,
    input  logic              FINE_CONTO,
    input  logic [1:0]        PARTITA,
    output logic              INIZIO_SETUP,
    output logic              INIZIO_CONTO,
    output logic [1:0]        RISULTATO,
    output logic              RISULTATO_VALIDO,
    input  logic              ACK,
    output logic              ERRORE,
    output logic [CONT_W-1:0] MANCHE_GIOCATE
);

    if (TIMEOUT_CICLI < 2) begin : g_check_timeout
        $error("TIMEOUT_CICLI must be at least 2");
    end

    stato_t            stato_q, stato_d;
    logic [CONT_W-1:0] limite_q, limite_d;
    logic [CONT_W-1:0] manche_q, manche_d;
    logic [1:0]        risultato_q, risultato_d;
    logic              errore_q, errore_d;

    logic overrun;
    logic timeout;

    assign overrun = (manche_q == (limite_q + CONT_W'(1)));

`ifdef CONTROLLO_TIMEOUT_EN
    contatore_timeout #(
        .LIMITE (TIMEOUT_CICLI)
    ) u_contatore_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     ((stato_q != GIOCO) || MOSSA_VALIDA),
        .conta     (stato_q == GIOCO),
        .terminale (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stato_q     <= RIPOSO;
            limite_q    <= '0;
            manche_q    <= '0;
            risultato_q <= ESITO_NESSUNO;
            errore_q    <= 1'b0;
        end else begin
            stato_q     <= stato_d;
            limite_q    <= limite_d;
            manche_q    <= manche_d;
            risultato_q <= risultato_d;
            errore_q    <= errore_d;
        end
    end

    always_comb begin
        stato_d = stato_q;
        unique case (stato_q)
            RIPOSO: if (INIZIO) stato_d = SETUP;
            SETUP:  stato_d = GIOCO;
            GIOCO:  if (FINE_CONTO || overrun || timeout) stato_d = FINE;
            FINE:   if (ACK) stato_d = RIPOSO;
            default: stato_d = RIPOSO;
        endcase
    end

    // A datapath decision always takes precedence over overrun or timeout on the same edge.
    always_comb begin
        limite_d    = limite_q;
        manche_d    = manche_q;
        risultato_d = risultato_q;
        errore_d    = errore_q;
        unique case (stato_q)
            RIPOSO: begin
                if (INIZIO) begin
                    manche_d    = '0;
                    risultato_d = ESITO_NESSUNO;
                    errore_d    = 1'b0;
                end
            end
            SETUP: begin
                limite_d = CONT_W'({SECONDO, PRIMO}) + CONT_W'(MANCHE_BASE);
            end
            GIOCO: begin
                if (MOSSA_VALIDA && (manche_q != {CONT_W{1'b1}})) begin
                    manche_d = manche_q + CONT_W'(1);
                end
                if (FINE_CONTO) begin
                    risultato_d = PARTITA;
                    errore_d    = 1'b0;
                end else if (overrun || timeout) begin
                    risultato_d = ESITO_NESSUNO;
                    errore_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        INIZIO_SETUP     = (stato_q == SETUP);
        INIZIO_CONTO     = (stato_q == GIOCO) && !FINE_CONTO;
        RISULTATO_VALIDO = (stato_q == FINE);
        RISULTATO        = risultato_q;
        ERRORE           = errore_q;
        MANCHE_GIOCATE   = manche_q;
    end

endmodule

// File: tb/tb_controllore_partita.sv
// Self-checking bench for controllore_partita: vector table with result scoreboard plus corner sequences.
module tb_controllore_partita;

    localparam int CONT_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              INIZIO, MOSSA_VALIDA, FINE_CONTO, ACK;
    logic [1:0]        PRIMO, SECONDO, PARTITA;
    logic              INIZIO_SETUP, INIZIO_CONTO, RISULTATO_VALIDO, ERRORE;
    logic [1:0]        RISULTATO;
    logic [CONT_W-1:0] MANCHE_GIOCATE;

    controllore_partita dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .INIZIO           (INIZIO),
        .MOSSA_VALIDA     (MOSSA_VALIDA),
        .PRIMO            (PRIMO),
        .SECONDO          (SECONDO),
        .FINE_CONTO       (FINE_CONTO),
        .PARTITA          (PARTITA),
        .INIZIO_SETUP     (INIZIO_SETUP),
        .INIZIO_CONTO     (INIZIO_CONTO),
        .RISULTATO        (RISULTATO),
        .RISULTATO_VALIDO (RISULTATO_VALIDO),
        .ACK              (ACK),
        .ERRORE           (ERRORE),
        .MANCHE_GIOCATE   (MANCHE_GIOCATE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cfg;
        int         n_moves;
        bit         fine;
        logic [1:0] partita;
    } vec_t;

    typedef struct {
        logic [1:0]        res;
        logic              err;
        logic [CONT_W-1:0] manche;
    } exp_t;

    vec_t vecs[8];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_match(input logic [3:0] cfg);
        INIZIO = 1'b1;
        {SECONDO, PRIMO} = cfg;
        tick();
        chk("setup_pulse", 32'(INIZIO_SETUP), 1);
        chk("manche_cleared", 32'(MANCHE_GIOCATE), 0);
        chk("errore_cleared", 32'(ERRORE), 0);
        INIZIO = 1'b0;
        tick();
        chk("setup_one_cycle", 32'(INIZIO_SETUP), 0);
        chk("conto_on", 32'(INIZIO_CONTO), 1);
    endtask

    task automatic play_moves(input int n);
        for (int i = 0; i < n; i++) begin
            MOSSA_VALIDA = 1'b1;
            PRIMO   = 2'($urandom);
            SECONDO = 2'($urandom);
            ACK     = 1'($urandom);
            INIZIO  = 1'($urandom);
            tick();
        end
        MOSSA_VALIDA = 1'b0;
        ACK = 1'b0;
        INIZIO = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        exp_t e;
        exp_t got;
        int   lim;
        bit   seen;
        lim = int'(v.cfg) + 4;
        e.manche = CONT_W'(v.n_moves);
        if (v.fine) begin
            e.res = v.partita;
            e.err = 1'b0;
        end else begin
            e.res = 2'b00;
            e.err = 1'b1;
        end
        if (!v.fine && v.n_moves != lim + 1)
            $display("note: vector cfg=%0h does not terminate", v.cfg);
        start_match(v.cfg);
        sb_q.push_back(e);
        play_moves(v.n_moves);
        if (v.fine) begin
            FINE_CONTO = 1'b1;
            PARTITA = v.partita;
            #1;
            chk("conto_mealy_off", 32'(INIZIO_CONTO), 0);
        end
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            tick();
            seen = RISULTATO_VALIDO;
        end
        FINE_CONTO = 1'b0;
        PARTITA = 2'($urandom);
        chk("valid_seen", 32'(seen), 1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            got = sb_q.pop_front();
            $display("match cfg=%0h moves=%0d fine=%0d -> RISULTATO=%0h ERRORE=%0b MANCHE=%0d (req %0h %0b %0d)",
                     v.cfg, v.n_moves, v.fine, RISULTATO, ERRORE, MANCHE_GIOCATE, got.res, got.err, got.manche);
            chk("risultato", 32'(RISULTATO), 32'(got.res));
            chk("errore", 32'(ERRORE), 32'(got.err));
            chk("manche", 32'(MANCHE_GIOCATE), 32'(got.manche));
            chk("conto_off_fine", 32'(INIZIO_CONTO), 0);
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("hold_valid", 32'(RISULTATO_VALIDO), 1);
                chk("hold_risultato", 32'(RISULTATO), 32'(got.res));
                chk("hold_errore", 32'(ERRORE), 32'(got.err));
            end
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("valid_dropped", 32'(RISULTATO_VALIDO), 0);
        chk("conto_riposo", 32'(INIZIO_CONTO), 0);
    endtask

    initial begin
        vecs[0] = '{cfg: 4'h0, n_moves: 2,  fine: 1'b1, partita: 2'b01};
        vecs[1] = '{cfg: 4'h0, n_moves: 5,  fine: 1'b0, partita: 2'b00};
        vecs[2] = '{cfg: 4'h3, n_moves: 8,  fine: 1'b0, partita: 2'b00};
        vecs[3] = '{cfg: 4'h3, n_moves: 8,  fine: 1'b1, partita: 2'b10};
        vecs[4] = '{cfg: 4'hF, n_moves: 3,  fine: 1'b1, partita: 2'b11};
        vecs[5] = '{cfg: 4'h5, n_moves: 0,  fine: 1'b1, partita: 2'b00};
        vecs[6] = '{cfg: 4'hA, n_moves: 15, fine: 1'b0, partita: 2'b00};
        vecs[7] = '{cfg: 4'h1, n_moves: 6,  fine: 1'b1, partita: 2'b11};

        rst_n = 1'b0;
        INIZIO = 0; MOSSA_VALIDA = 0; FINE_CONTO = 0; ACK = 0;
        PRIMO = 0; SECONDO = 0; PARTITA = 0;
        #12;
        chk("reset_outputs", 32'({INIZIO_SETUP, INIZIO_CONTO, RISULTATO, RISULTATO_VALIDO, ERRORE, MANCHE_GIOCATE}), 0);
        tick();
        rst_n = 1'b1;

        // ACK and stray moves while idle must do nothing
        ACK = 1'b1;
        MOSSA_VALIDA = 1'b1;
        tick();
        ACK = 1'b0;
        MOSSA_VALIDA = 1'b0;
        chk("idle_ack_ignored", 32'({INIZIO_SETUP, RISULTATO_VALIDO, MANCHE_GIOCATE}), 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], (i == 0) ? 5 : 1);
        end

        // Asynchronous abort mid-match
        start_match(4'h2);
        play_moves(2);
        chk("manche_before_abort", 32'(MANCHE_GIOCATE), 2);
        rst_n = 1'b0;
        #1;
        chk("async_abort", 32'({INIZIO_SETUP, INIZIO_CONTO, RISULTATO, RISULTATO_VALIDO, ERRORE, MANCHE_GIOCATE}), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_no_result", 32'({RISULTATO_VALIDO, INIZIO_CONTO}), 0);

        // Idle behaviour in GIOCO
        start_match(4'h0);
`ifdef CONTROLLO_TIMEOUT_EN
        repeat (63) tick();
        chk("timeout_not_yet", 32'(RISULTATO_VALIDO), 0);
        tick();
        chk("timeout_fine", 32'(RISULTATO_VALIDO), 1);
        chk("timeout_errore", 32'(ERRORE), 1);
        chk("timeout_risultato", 32'(RISULTATO), 0);
`else
        repeat (100) tick();
        chk("no_timeout_valid", 32'(RISULTATO_VALIDO), 0);
        chk("no_timeout_conto", 32'(INIZIO_CONTO), 1);
        FINE_CONTO = 1'b1;
        PARTITA = 2'b10;
        tick();
        FINE_CONTO = 1'b0;
        chk("late_fine_valid", 32'(RISULTATO_VALIDO), 1);
        chk("late_fine_risultato", 32'(RISULTATO), 2);
`endif
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("final_riposo", 32'(RISULTATO_VALIDO), 0);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
